cc_game_ctrl: RTL and testbench
===============================

# cc_game_ctrl

Game supervisor for the cc player column. It generates scrolling obstacle walls that each have a single gap, moves them toward the player column on the same tick cadence as the per-LED controllers, and detects collisions against the player light vector. It drives the shared `active`/`over` controls that every player-LED controller consumes, and keeps a score. It sits between the debounced start key and the player-LED array, and feeds the LED-matrix display.

## Interface
- `ROWS`, 8: player column height; must be 4 or 8.
- `DIST`, 4: number of obstacle columns, with stage 0 at the player column.
- `SPACING`, 3: ticks between wall spawns; must be ≥1.
- `TICK_W`, 7: tick divider width; one tick every 2^TICK_W cycles.
- `SCORE_W`, 10: score width.

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  debounced key level; rising edge detected internally
- `player`  in  ROWS  player light vector from the player-LED array; bit 0 is the bottom row
- `active`  out  1  high in PLAY and OVER
- `over`  out  1  high in OVER only
- `field`  out  DIST*ROWS  obstacle columns; stage k occupies bits [k*ROWS +: ROWS]
- `score`  out  SCORE_W  walls passed, saturating

## Operation
- FSM states: IDLE, PLAY, OVER.
  - IDLE → PLAY on a start rising edge.
  - PLAY → OVER on collision.
  - OVER → IDLE on a start rising edge.
  - A start edge in PLAY is ignored.
- All outputs are registered. Output decode:
  - IDLE: active=0, over=0.
  - PLAY: active=1, over=0.
  - OVER: active=1, over=1. Active stays high so the player LEDs freeze rather than reload their defaults.
- Entering PLAY from IDLE clears `field`, `score`, the tick counter and the spawn counter.
- Tick counter:
  - Held at 0 outside PLAY.
  - In PLAY it increments every cycle and wraps modulo 2^TICK_W.
  - A tick occurs on every PLAY cycle where the counter is 0.
- On a tick:
  - Stage k takes the value of stage k+1.
  - Stage DIST-1 takes the spawn column.
  - Stage 0's old value is discarded. If that value was nonzero, `score` increments, saturating at all-ones.
- Spawn counter:
  - Counts ticks modulo SPACING.
  - When it is 0 on a tick, the spawn column is a wall, ~(1 << gap), with gap = lfsr[log2(ROWS)-1:0].
  - Otherwise the spawn column is all zeros.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5.
  - Advances once per tick, after its value is sampled for the gap.
- Collision:
  - Evaluated every PLAY cycle as |(player & stage0).
  - When it is true, the next state is OVER.
  - `field`, `score` and the LFSR freeze in OVER.
  - If a collision and a tick occur in the same cycle, the collision wins: no shift and no score update happen that cycle.
- OVER → IDLE clears `field` but keeps `score` until the next PLAY entry.

## Timing
- Reset values: state IDLE, active=0, over=0, field=0, score=0, lfsr=8'hA5, all counters 0.
- Clock edge E enters PLAY. The first tick is at E+1, which is the same edge on which the player LEDs take their first step. Later ticks fall at E+1+n·2^TICK_W.
- A wall spawned at tick t reaches stage 0 at tick t+DIST-1. It scores at tick t+DIST.
- Collision latency: `over` rises on the edge after the cycle in which the overlap is present.
- Start edge detection uses a registered previous value of `start`. The state transition therefore occurs on the edge after the rising edge of `start` is sampled.
- Reset asserted in any state forces the reset values on the next edge.

## Configuration
- `CC_GAME_LFSR_IDLE_EN`:
  - Defined: the LFSR also advances every cycle in IDLE, so wall gaps depend on when the player presses start.
  - Undefined: the LFSR advances only on ticks, making the gap sequence deterministic from reset.

## Structure
- `cc_pkg` holds:
  - the state enum `cc_state_t`;
  - `CC_LFSR_SEED` = 8'hA5;
  - `CC_LFSR_TAPS`;
  - a function that builds a wall column from a gap index.
- Sub-module `cc_lfsr8`, with ports clk, reset, adv, q, provides the LFSR.
- Everything else lives in `cc_game_ctrl`.

## Test plan
All scenarios run with the macro undefined, TICK_W=2, ROWS=8, DIST=4, SPACING=3.
- Reset, then idle for 20 cycles → active=0, over=0, field=0, score=0. Start pulse → active=1 two edges later.
- First tick after PLAY entry → stage 3 = ~(1 << 5), because the seed's low bits are 3'b101. Stage 3's value moves to stage 0 after 3 more ticks, i.e. 12 cycles.
- Hold `player` equal to the gap bit of every wall → no collision. Score reaches 1 at tick 5 and increments every 3 ticks thereafter. Force the score to all-ones → it holds.
- Set `player` = 8'h01 while a wall with gap≠0 reaches stage 0 → over=1 on the next edge and active stays 1. `field` and `score` are unchanged for 10 further cycles.
- Apply a collision on a tick cycle → no shift and no score increment that cycle. In OVER, a start edge → IDLE with field=0. A second start edge → PLAY with score=0.
- Assert reset mid-PLAY → all reset values on the next edge. A start edge in PLAY → state is unchanged.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared types and constants for the cc game supervisor.
package cc_pkg;

  typedef enum logic [1:0] {
    CC_IDLE = 2'd0,
    CC_PLAY = 2'd1,
    CC_OVER = 2'd2
  } cc_state_t;

  localparam logic [7:0] CC_LFSR_SEED = 8'hA5;
  // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register.
  localparam logic [7:0] CC_LFSR_TAPS = 8'hB8;

  // Full-width wall: every row lit except the gap row.
  function automatic logic [7:0] cc_wall(input logic [7:0] gap);
    return ~(8'd1 << gap);
  endfunction

endpackage

// File: rtl/cc_lfsr8.sv
// 8-bit Fibonacci LFSR that supplies wall gap positions; steps only when adv is high.
module cc_lfsr8
  import cc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       adv,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv) lfsr_d = {lfsr_q[6:0], ^(lfsr_q & CC_LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= CC_LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/cc_game_ctrl.sv
// Game supervisor: scrolls gapped walls toward the player column, detects collisions, keeps score.
// Optional build macro CC_GAME_LFSR_IDLE_EN lets the LFSR free-run in IDLE.
module cc_game_ctrl
  import cc_pkg::*;
#(
  parameter int ROWS    = 8,
  parameter int DIST    = 4,
  parameter int SPACING = 3,
  parameter int TICK_W  = 7,
  parameter int SCORE_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ROWS-1:0]      player,
  output logic                 active,
  output logic                 over,
  output logic [DIST*ROWS-1:0] field,
  output logic [SCORE_W-1:0]   score
);

  localparam int SP_W = (SPACING > 1) ? $clog2(SPACING) : 1;

  cc_state_t            state_q, state_d;
  logic                 active_q, active_d;
  logic                 over_q, over_d;
  logic [DIST*ROWS-1:0] field_q, field_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [SP_W-1:0]      spawn_cnt_q, spawn_cnt_d;
  logic                 start_q, start_prev_q;

  logic                 start_rise;
  logic                 collision;
  logic                 tick;
  logic                 lfsr_adv;
  logic [7:0]           lfsr;
  logic [7:0]           wall_full;
  logic [ROWS-1:0]      spawn_col;

  cc_lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .adv   (lfsr_adv),
    .q     (lfsr)
  );

  assign wall_full = cc_wall(lfsr & 8'(ROWS - 1));

  always_comb begin
    state_d     = state_q;
    field_d     = field_q;
    score_d     = score_q;
    tick_cnt_d  = '0;
    spawn_cnt_d = spawn_cnt_q;
    lfsr_adv    = 1'b0;
    start_rise  = start_q & ~start_prev_q;
    collision   = |(player & field_q[ROWS-1:0]);
    tick        = (state_q == CC_PLAY) && (tick_cnt_q == '0);
    spawn_col   = (spawn_cnt_q == '0) ? wall_full[ROWS-1:0] : '0;

    case (state_q)
      CC_IDLE: begin
`ifdef CC_GAME_LFSR_IDLE_EN
        lfsr_adv = 1'b1;
`endif
        if (start_rise) begin
          state_d     = CC_PLAY;
          field_d     = '0;
          score_d     = '0;
          spawn_cnt_d = '0;
        end
      end
      CC_PLAY: begin
        // A collision on a tick cycle suppresses the shift and the score update.
        if (collision) begin
          state_d = CC_OVER;
        end else begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick) begin
            lfsr_adv = 1'b1;
            field_d  = {spawn_col, field_q[DIST*ROWS-1:ROWS]};
            if ((field_q[ROWS-1:0] != '0) && (score_q != '1))
              score_d = score_q + SCORE_W'(1);
            spawn_cnt_d = (spawn_cnt_q == SP_W'(SPACING - 1)) ? '0 : spawn_cnt_q + SP_W'(1);
          end
        end
      end
      CC_OVER: begin
        if (start_rise) begin
          state_d = CC_IDLE;
          field_d = '0;
        end
      end
      default: state_d = CC_IDLE;
    endcase

    active_d = (state_d != CC_IDLE);
    over_d   = (state_d == CC_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CC_IDLE;
      active_q     <= 1'b0;
      over_q       <= 1'b0;
      field_q      <= '0;
      score_q      <= '0;
      tick_cnt_q   <= '0;
      spawn_cnt_q  <= '0;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      over_q       <= over_d;
      field_q      <= field_d;
      score_q      <= score_d;
      tick_cnt_q   <= tick_cnt_d;
      spawn_cnt_q  <= spawn_cnt_d;
      start_q      <= start;
      start_prev_q <= start_q;
    end
  end

  assign active = active_q;
  assign over   = over_q;
  assign field  = field_q;
  assign score  = score_q;

endmodule

// File: tb/tb_cc_game_ctrl.sv
// Self-checking bench for cc_game_ctrl against a cycle-level behavioural game model.
module tb_cc_game_ctrl;

  localparam int ROWS = 8, DIST = 4, SPACING = 3, TICK_W = 2, SCORE_W = 10;
  localparam int PERIOD = 1 << TICK_W;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [ROWS-1:0]      player = '0;
  logic                 active, over;
  logic [DIST*ROWS-1:0] field;
  logic [SCORE_W-1:0]   score;

  int checks = 0;
  int errors = 0;

  // Behavioural model: 0 = idle, 1 = playing, 2 = game over.
  int         mst;
  logic [7:0] mf [DIST];
  int         mscore;
  logic [7:0] mlfsr;
  int         mpc;
  int         mnt;
  bit         ms1, ms2;

  cc_game_ctrl #(
    .ROWS(ROWS), .DIST(DIST), .SPACING(SPACING), .TICK_W(TICK_W), .SCORE_W(SCORE_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .player (player),
    .active (active),
    .over   (over),
    .field  (field),
    .score  (score)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [31:0] model_field();
    logic [31:0] r = '0;
    for (int k = 0; k < DIST; k++) r[k*ROWS +: ROWS] = mf[k];
    return r;
  endfunction

  task automatic model_update();
    bit rise;
    if (reset) begin
      mst = 0; mscore = 0; mlfsr = 8'hA5; mpc = 0; mnt = 0; ms1 = 0; ms2 = 0;
      for (int k = 0; k < DIST; k++) mf[k] = '0;
    end else begin
      rise = ms1 && !ms2;
      case (mst)
        0: if (rise) begin
          mst = 1; mscore = 0; mpc = 0; mnt = 0;
          for (int k = 0; k < DIST; k++) mf[k] = '0;
        end
        1: if ((player & mf[0]) != 0) begin
          mst = 2;
        end else begin
          if (mpc % PERIOD == 0) begin
            if (mf[0] != 0 && mscore < SCORE_MAX) mscore++;
            for (int k = 0; k < DIST - 1; k++) mf[k] = mf[k+1];
            mf[DIST-1] = (mnt % SPACING == 0) ? ~(8'd1 << (mlfsr % ROWS)) : 8'd0;
            mlfsr = lfsr_next(mlfsr);
            mnt++;
          end
          mpc++;
        end
        default: if (rise) begin
          mst = 0;
          for (int k = 0; k < DIST; k++) mf[k] = '0;
        end
      endcase
      ms2 = ms1;
      ms1 = start;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    chk("active", 32'(active), 32'(mst != 0));
    chk("over",   32'(over),   32'(mst == 2));
    chk("field",  field,       model_field());
    chk("score",  32'(score),  32'(mscore));
  endtask

  // A player vector that cannot overlap the wall currently at stage 0.
  function automatic logic [ROWS-1:0] safe_player();
    if (mf[0] == 0) return ROWS'($urandom);
    return ($urandom_range(0, 1) == 1) ? ~mf[0] : '0;
  endfunction

  task automatic safe_steps(input int n);
    for (int i = 0; i < n; i++) begin
      player = safe_player();
      step();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; player = safe_player(); step();
    start = 1'b0; player = safe_player(); step();
  endtask

  logic [31:0] saved_field;
  int          saved_score;
  int          budget;

  initial begin
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      player = ROWS'($urandom);
      step();
    end
    chk("idle_active", 32'(active), 0);
    chk("idle_field", field, 0);

    // Start pulse: active rises on the second edge.
    start = 1'b1; step();
    chk("active_edge1", 32'(active), 0);
    start = 1'b0; step();
    chk("active_edge2", 32'(active), 1);

    safe_steps(1);
    chk("first_wall_stage3", 32'(field[3*ROWS +: ROWS]), 32'hDF);
    safe_steps(PERIOD * 3);
    chk("first_wall_stage0", 32'(field[ROWS-1:0]), 32'hDF);
    chk("score_before_tick5", 32'(score), 0);
    safe_steps(PERIOD);
    chk("score_tick5", 32'(score), 1);
    safe_steps(PERIOD * SPACING);
    chk("score_tick8", 32'(score), 2);

    // Start edge while playing is ignored.
    pulse_start();
    chk("start_in_play_active", 32'(active), 1);
    chk("start_in_play_over", 32'(over), 0);

    // Run to saturation, then beyond it.
    budget = 0;
    while (mscore < SCORE_MAX && budget < 20000) begin
      safe_steps(1);
      budget++;
    end
    chk("saturate_reached", 32'(mscore), SCORE_MAX);
    safe_steps(PERIOD * SPACING * 3);
    chk("score_saturated", 32'(score), SCORE_MAX);

    // Collision on a tick cycle.
    budget = 0;
    while (!(mst == 1 && mpc % PERIOD == 0 && mf[0] != 0) && budget < 200) begin
      safe_steps(1);
      budget++;
    end
    chk("tick_collision_found", 32'(budget < 200), 1);
    saved_field = field;
    saved_score = int'(score);
    player = mf[0];
    step();
    chk("tick_coll_over", 32'(over), 1);
    chk("tick_coll_no_shift", field, saved_field);
    chk("tick_coll_no_score", 32'(score), 32'(saved_score));
    for (int i = 0; i < 10; i++) begin
      player = ROWS'($urandom);
      step();
    end
    chk("over_frozen_field", field, saved_field);

    pulse_start();
    chk("over_to_idle_active", 32'(active), 0);
    chk("over_to_idle_field", field, 0);
    chk("idle_keeps_score", 32'(score), 32'(saved_score));
    pulse_start();
    chk("replay_active", 32'(active), 1);
    chk("replay_score", 32'(score), 0);

    // Bottom-row player hits the first wall whose gap is not row 0.
    budget = 0;
    while (mst == 1 && budget < 400) begin
      player = 8'h01;
      step();
      budget++;
    end
    chk("bottom_collision_found", 32'(mst), 2);
    chk("bottom_coll_over", 32'(over), 1);
    chk("bottom_coll_active", 32'(active), 1);
    saved_field = field;
    saved_score = int'(score);
    for (int i = 0; i < 10; i++) begin
      player = ROWS'($urandom);
      step();
    end
    chk("bottom_frozen_field", field, saved_field);
    chk("bottom_frozen_score", 32'(score), 32'(saved_score));

    // Reset in the middle of a game.
    pulse_start();
    pulse_start();
    safe_steps(30);
    reset = 1'b1;
    step();
    chk("reset_active", 32'(active), 0);
    chk("reset_field", field, 0);
    chk("reset_score", 32'(score), 0);
    reset = 1'b0;
    safe_steps(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
